// File: rtl/riscv_pkg.sv
// Shared register-file constants and writeback payload types.
//   ADDRESS_LENGTH / WIDTH / SIZE : register address width, data width, register count
//   reg_addr_t                    : register index
//   wb_req_t                      : one write request {valid, rd, data}
//   wb_src_t                      : which requester owns the write port this cycle
package riscv_pkg;

    localparam int unsigned ADDRESS_LENGTH = 5;
    localparam int unsigned WIDTH          = 32;
    localparam int unsigned SIZE           = 1 << ADDRESS_LENGTH;

    typedef logic [ADDRESS_LENGTH-1:0] reg_addr_t;

    typedef struct packed {
        logic             valid;
        reg_addr_t        rd;
        logic [WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_HOLD,
        SRC_FORCE_B,
        SRC_A,
        SRC_B
    } wb_src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for registers awaiting a long-latency result.
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_rd    : mark set_rd pending (op dispatched)
//   clr_en, clr_rd    : clear clr_rd (result accepted)
//   hold_valid/hold_rd: parked writeback entry, reported busy while parked
//   busy              : pending vector, bit 0 always 0
module wb_scoreboard #(
    parameter int unsigned ADDRESS_LENGTH = riscv_pkg::ADDRESS_LENGTH,
    parameter int unsigned SIZE           = 1 << ADDRESS_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [ADDRESS_LENGTH-1:0] set_rd,
    input  logic                      clr_en,
    input  logic [ADDRESS_LENGTH-1:0] clr_rd,
    input  logic                      hold_valid,
    input  logic [ADDRESS_LENGTH-1:0] hold_rd,
    output logic [SIZE-1:0]           busy
);

    logic [SIZE-1:0] sb_q;
    logic [SIZE-1:0] sb_d;
    logic [SIZE-1:0] hold_mask;

    // Clear first so a same-register set in the same cycle wins.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            sb_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // A parked write is still outstanding from the hazard unit's view.
    always_comb begin
        hold_mask = '0;
        if (hold_valid) begin
            hold_mask = SIZE'(1) << hold_rd;
        end
        busy = (sb_q | hold_mask) & ~SIZE'(1);
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback (port A, no backpressure) and the long-latency unit (port B,
// valid/ready). A one-entry hold buffer lets a starved port B be forced in
// while the colliding port A write lands one cycle later.
//   clk, rst                      : clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data        : port A request
//   mc_valid/mc_ready/mc_rd/mc_data : port B handshake and payload
//   mc_issue/mc_issue_rd          : long-latency dispatch, marks rd busy
//   rf_we/rf_waddr/rf_wdata       : register file write port (combinational)
//   busy                          : pending registers (scoreboard | hold entry)
//   stall                         : pipeline must hold wb_valid low
module wb_port_arbiter #(
    parameter int unsigned WIDTH          = riscv_pkg::WIDTH,
    parameter int unsigned ADDRESS_LENGTH = riscv_pkg::ADDRESS_LENGTH,
    parameter int unsigned SIZE           = 1 << ADDRESS_LENGTH,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_valid,
    input  logic [ADDRESS_LENGTH-1:0] wb_rd,
    input  logic [WIDTH-1:0]          wb_data,
    input  logic                      mc_valid,
    output logic                      mc_ready,
    input  logic [ADDRESS_LENGTH-1:0] mc_rd,
    input  logic [WIDTH-1:0]          mc_data,
    input  logic                      mc_issue,
    input  logic [ADDRESS_LENGTH-1:0] mc_issue_rd,
    output logic                      rf_we,
    output logic [ADDRESS_LENGTH-1:0] rf_waddr,
    output logic [WIDTH-1:0]          rf_wdata,
    output logic [SIZE-1:0]           busy,
    output logic                      stall
);

    import riscv_pkg::*;

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    wb_req_t          hold_q;
    wb_req_t          hold_d;
    wb_src_t          src;
    logic             a_req;
    logic             force_b;
    logic             mc_accept;
    logic [SIZE-1:0]  busy_raw;

    // Port grant. Port A is ignored while the hold entry drains (stall).
    always_comb begin
        a_req     = wb_valid && (wb_rd != '0) && !hold_q.valid;
        force_b   = (starve_cnt == CNT_W'(STARVE_LIMIT));
        mc_ready  = !rst && !hold_q.valid && (force_b || !a_req);
        mc_accept = mc_valid && mc_ready;
        stall     = !rst && hold_q.valid;

        src = SRC_NONE;
        if (rst) begin
            src = SRC_NONE;
        end else if (hold_q.valid) begin
            src = SRC_HOLD;
        end else if (force_b && mc_valid) begin
            src = SRC_FORCE_B;
        end else if (a_req) begin
            src = SRC_A;
        end else if (mc_valid) begin
            src = SRC_B;
        end
    end

    // Write port mux and hold capture. A port B result for x0 completes
    // its handshake but never reaches the register file.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        hold_d   = '0;
        case (src)
            SRC_HOLD: begin
                rf_we    = 1'b1;
                rf_waddr = hold_q.rd;
                rf_wdata = hold_q.data;
            end
            SRC_FORCE_B: begin
                rf_we    = (mc_rd != '0);
                rf_waddr = mc_rd;
                rf_wdata = mc_data;
                if (a_req) begin
                    hold_d.valid = 1'b1;
                    hold_d.rd    = wb_rd;
                    hold_d.data  = wb_data;
                end
            end
            SRC_A: begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_data;
            end
            SRC_B: begin
                rf_we    = (mc_rd != '0);
                rf_waddr = mc_rd;
                rf_wdata = mc_data;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    // Starvation counter saturates at the limit and holds force until B is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            hold_q     <= '0;
        end else begin
            hold_q <= hold_d;
            if (mc_accept || !mc_valid) begin
                starve_cnt <= '0;
            end else if (!force_b) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    wb_scoreboard #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH),
        .SIZE           (SIZE)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (mc_issue && (mc_issue_rd != '0)),
        .set_rd     (mc_issue_rd),
        .clr_en     (mc_accept),
        .clr_rd     (mc_rd),
        .hold_valid (hold_q.valid),
        .hold_rd    (hold_q.rd),
        .busy       (busy_raw)
    );

    assign busy = rst ? '0 : busy_raw;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: write-port priority, starvation
// forcing with hold buffer, scoreboard set/clear, x0 handling and reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        stall;

    int checks = 0;
    int fails  = 0;

    wb_port_arbiter #(
        .WIDTH          (32),
        .ADDRESS_LENGTH (5),
        .SIZE           (32),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline contract: no port A request while stall is raised.
    always @(negedge clk) begin
        if (!rst && stall === 1'b1 && wb_valid === 1'b1) begin
            fails++;
            checks++;
            $display("FAIL stall_contract: wb_valid=1 while stall=1 at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md,
                          input logic iv, input logic [4:0] ir);
        wb_valid    = wv;
        wb_rd       = wr;
        wb_data     = wd;
        mc_valid    = mv;
        mc_rd       = mr;
        mc_data     = md;
        mc_issue    = iv;
        mc_issue_rd = ir;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h6666, 1'b1, 5'd2);
        #1;
        checks++;
        if ({rf_we, mc_ready, stall} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: got we/ready/stall=%b expected 000", {rf_we, mc_ready, stall});
        end
        checks++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL reset_busy: got %h expected 00000000", busy);
        end
        tick();
        tick();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, stall, busy} !== 34'h0) begin
            fails++;
            $display("FAIL post_reset_idle: got we=%b stall=%b busy=%h expected 0 0 0", rf_we, stall, busy);
        end
        tick();
    endtask

    task automatic test_port_a();
        set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
            fails++;
            $display("FAIL port_a_write: got we=%b a=%0d d=%h rdy=%b expected 1 5 deadbeef 0",
                     rf_we, rf_waddr, rf_wdata, mc_ready);
        end
        checks++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL port_a_busy: got %h expected 00000000", busy);
        end
        tick();
    endtask

    task automatic test_port_b_idle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick();
        checks++;
        if (busy !== 32'h0000_0080) begin
            fails++;
            $display("FAIL issue_7_busy: got %h expected 00000080", busy);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b1, 5'd7, 32'h12, 1'b1}) begin
            fails++;
            $display("FAIL port_b_idle_write: got we=%b a=%0d d=%h rdy=%b expected 1 7 00000012 1",
                     rf_we, rf_waddr, rf_wdata, mc_ready);
        end
        tick();
        checks++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL port_b_clear_7: got %h expected 00000000", busy);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
    endtask

    task automatic test_starvation();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        tick();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'd9, 32'h900 + 32'(i), 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
            #1;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata, mc_ready, stall} !== {1'b1, 5'd9, 32'h900 + 32'(i), 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL starve_cycle_%0d: got we=%b a=%0d d=%h rdy=%b stall=%b expected 1 9 %h 0 0",
                         i, rf_we, rf_waddr, rf_wdata, mc_ready, stall, 32'h900 + 32'(i));
            end
            tick();
        end
        set_in(1'b1, 5'd9, 32'h905, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b1, 5'd3, 32'h33, 1'b1}) begin
            fails++;
            $display("FAIL starve_forced_b: got we=%b a=%0d d=%h rdy=%b expected 1 3 00000033 1",
                     rf_we, rf_waddr, rf_wdata, mc_ready);
        end
        tick();
        checks++;
        if ({stall, busy} !== {1'b1, 32'h0000_0200}) begin
            fails++;
            $display("FAIL starve_hold_state: got stall=%b busy=%h expected 1 00000200", stall, busy);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b1, 5'd9, 32'h905, 1'b0}) begin
            fails++;
            $display("FAIL starve_hold_write: got we=%b a=%0d d=%h rdy=%b expected 1 9 00000905 0",
                     rf_we, rf_waddr, rf_wdata, mc_ready);
        end
        tick();
        checks++;
        if ({stall, busy} !== 33'h0) begin
            fails++;
            $display("FAIL starve_drained: got stall=%b busy=%h expected 0 00000000", stall, busy);
        end
    endtask

    task automatic test_scoreboard_race();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        #1;
        checks++;
        if ({mc_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd4}) begin
            fails++;
            $display("FAIL race_accept: got rdy=%b we=%b a=%0d expected 1 1 4", mc_ready, rf_we, rf_waddr);
        end
        tick();
        checks++;
        if (busy !== 32'h0000_0010) begin
            fails++;
            $display("FAIL race_set_wins: got %h expected 00000010", busy);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        tick();
        checks++;
        if (busy !== 32'h0000_0010) begin
            fails++;
            $display("FAIL issue_x0: got %h expected 00000010", busy);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0);
        tick();
        checks++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL race_cleanup: got %h expected 00000000", busy);
        end
    endtask

    task automatic test_x0();
        set_in(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, mc_ready} !== {1'b1, 5'd6, 32'h66, 1'b1}) begin
            fails++;
            $display("FAIL x0_a_dropped: got we=%b a=%0d d=%h rdy=%b expected 1 6 00000066 1",
                     rf_we, rf_waddr, rf_wdata, mc_ready);
        end
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, mc_ready} !== 2'b01) begin
            fails++;
            $display("FAIL x0_b_no_write: got we=%b rdy=%b expected 0 1", rf_we, mc_ready);
        end
        tick();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 5'd9, 32'hB00 + 32'(i), 1'b1, 5'd3, 32'h34, 1'b0, 5'd0);
            tick();
        end
        checks++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL mid_hold_setup: got stall=%b expected 1", stall);
        end
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, stall, mc_ready, busy} !== 35'h0) begin
            fails++;
            $display("FAIL mid_hold_rst_cycle: got we=%b stall=%b rdy=%b busy=%h expected 0 0 0 0",
                     rf_we, stall, mc_ready, busy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({rf_we, stall, busy} !== 34'h0) begin
            fails++;
            $display("FAIL mid_hold_after: got we=%b stall=%b busy=%h expected 0 0 0", rf_we, stall, busy);
        end
        tick();
        // Counter restarted at 0: port B is refused exactly four cycles again.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 5'd9, 32'hC00 + 32'(i), 1'b1, 5'd3, 32'h35, 1'b0, 5'd0);
            #1;
            checks++;
            if (mc_ready !== (i == 4)) begin
                fails++;
                $display("FAIL mid_hold_starve_%0d: got rdy=%b expected %b", i, mc_ready, (i == 4));
            end
            tick();
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hC04}) begin
            fails++;
            $display("FAIL mid_hold_drain: got we=%b a=%0d d=%h expected 1 9 00000c04", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        test_reset();
        test_port_a();
        test_port_b_idle();
        test_starvation();
        test_scoreboard_race();
        test_x0();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port (we3/a3/wd3) between two writers. The in-order pipeline writeback (port A) has no backpressure. The long-latency unit result (port B: divider/load miss) uses a valid/ready handshake. A busy scoreboard of registers with outstanding long-latency results drives the hazard unit. A one-entry hold buffer, plus a stall request, prevents port B starvation. Sits between the writeback stage, the multi-cycle unit and register_file.

Parameters:
WIDTH, 32, data width of a register
ADDRESS_LENGTH, 5, register address width
SIZE, 1 << ADDRESS_LENGTH, number of registers / scoreboard bits
STARVE_LIMIT, 4, consecutive refused port-B cycles before port B is forced (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wb_valid  in  1  port A write request (no backpressure)
wb_rd  in  ADDRESS_LENGTH  port A destination
wb_data  in  WIDTH  port A data
mc_valid  in  1  port B result valid
mc_ready  out  1  port B accepted this cycle when mc_valid&&mc_ready
mc_rd  in  ADDRESS_LENGTH  port B destination
mc_data  in  WIDTH  port B data
mc_issue  in  1  long-latency op dispatched this cycle
mc_issue_rd  in  ADDRESS_LENGTH  destination of dispatched op
rf_we  out  1  to register_file we3
rf_waddr  out  ADDRESS_LENGTH  to register_file a3
rf_wdata  out  WIDTH  to register_file wd3
busy  out  SIZE  bit i set: register i pending (scoreboard | hold entry)
stall  out  1  pipeline must keep wb_valid low while set

Behaviour:
- State: starve_cnt (saturating, 0..STARVE_LIMIT), hold_valid/hold_rd/hold_data, busy_sb[SIZE]. All are flops on posedge clk.
- The write port is combinational, latency 0. register_file commits at the same edge.
- a_req = wb_valid && wb_rd != 0. Port A writes to x0 are dropped and never use the port.
- force = (starve_cnt == STARVE_LIMIT).
- mc_ready = !hold_valid && (force || !a_req). It is independent of mc_valid.
- Priority per cycle:
  1. hold_valid: write hold entry.
  2. force && mc_valid: write port B; if a_req, capture A into hold (hold_valid<=1).
  3. a_req: write port A.
  4. mc_valid: write port B.
  5. Otherwise rf_we=0.
- A port B write with mc_rd == 0 is accepted (handshake completes) but rf_we=0.
- stall = hold_valid. The pipeline contract is wb_valid=0 whenever stall=1. A violating wb_valid during stall is ignored; the bench flags it as an assertion.
- starve_cnt:
  - Reset to 0 on a port B accept or when mc_valid=0.
  - Otherwise +1 per cycle with mc_valid && !mc_ready, saturating at STARVE_LIMIT.
- Scoreboard:
  - Set: mc_issue && mc_issue_rd != 0 sets busy_sb[mc_issue_rd].
  - Clear: a port B accept clears busy_sb[mc_rd].
  - Same rd set and cleared in the same cycle: set wins.
- busy = busy_sb | (hold_valid ? onehot(hold_rd) : 0). Bit 0 is always 0.
- Reset (rst=1 at edge):
  - starve_cnt=0, hold_valid=0, busy_sb=0. Any held write is discarded.
  - During the rst cycle: rf_we=0, mc_ready=0, stall=0, busy=0.
- Ordering: a held A write lands exactly one cycle after the forced B write. A same-rd collision therefore leaves the A value (program order).

Decomposition:
- Shared package (riscv_pkg): ADDRESS_LENGTH/WIDTH constants, the reg_addr_t typedef, and a wb_req_t struct {valid, rd, data}.
- Natural sub-module: wb_scoreboard (set/clear/busy vector), instantiated once.

Test Plan:
- Port A only: wb_valid=1, rd=5, data=0xDEADBEEF → rf_we=1, waddr=5, wdata=0xDEADBEEF the same cycle; mc_ready=0; busy=0.
- Port B idle slot: wb_valid=0, mc_valid=1, rd=7, data=0x12 → mc_ready=1, rf_we=1, waddr=7; busy[7] falls 1→0 if previously issued.
- Starvation: mc_valid=1 (rd=3, data=0x33) while port A writes every cycle with rd=9.
  - Cycles 1–4 (STARVE_LIMIT=4) go to port A.
  - Cycle 5 writes x3=0x33 and captures A; stall=1, busy[9]=1.
  - Cycle 6 writes the held x9; stall=0.
- Scoreboard race: mc_issue rd=4 in the same cycle as a port B accept of rd=4 → busy[4]=1 afterwards; issue rd=0 → busy unchanged.
- x0 writes: wb_valid=1 with rd=0 and mc_valid=1 with rd=6 → B granted, rf_we writes x6; the x0 write is dropped.
- Reset mid-hold: assert rst in the cycle with hold_valid=1 → no write that cycle; the following cycle has stall=0, busy=0, starve_cnt=0.
